// File: rtl/gemm_cfg_pkg.sv
// Shared types and register map for the GEMM command queue.
// The descriptor carries dimensions at their maximum width; the top level trims them to DIM_W.
package gemm_cfg_pkg;

    localparam int DIM_MAX_W = 10;

    typedef struct packed {
        logic [31:0]          a_addr;
        logic [31:0]          b_addr;
        logic [31:0]          c_addr;
        logic [31:0]          a_stride;
        logic [31:0]          b_stride;
        logic [DIM_MAX_W-1:0] m;
        logic [DIM_MAX_W-1:0] k;
        logic [DIM_MAX_W-1:0] n;
        logic                 store;
        logic                 overwrite;
    } gemm_desc_t;

    localparam logic [31:0] REG_A_ADDR   = 32'h00;
    localparam logic [31:0] REG_B_ADDR   = 32'h04;
    localparam logic [31:0] REG_C_ADDR   = 32'h08;
    localparam logic [31:0] REG_A_STRIDE = 32'h0C;
    localparam logic [31:0] REG_B_STRIDE = 32'h10;
    localparam logic [31:0] REG_CTRL     = 32'h14;
    localparam logic [31:0] REG_DIM      = 32'h18;
    localparam logic [31:0] REG_COMMIT   = 32'h1C;
    localparam logic [31:0] REG_STATUS   = 32'h20;
    localparam logic [31:0] REG_DONE_CNT = 32'h24;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_OVERFLOW  = 16;
    localparam int ST_DONE_PEND = 17;

    localparam int CTRL_STORE     = 0;
    localparam int CTRL_OVERWRITE = 1;
    localparam int CTRL_IRQ_EN    = 2;

endpackage

// File: rtl/desc_fifo.sv
// First-word fall-through FIFO of GEMM descriptors.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module desc_fifo
    import gemm_cfg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  gemm_desc_t                   din,
    output gemm_desc_t                   dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    gemm_desc_t        r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_pop;
    logic              w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // When full, the write slot equals the slot being popped this edge.
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gemm_cmd_queue.sv
// Memory-mapped GEMM command queue: staging registers, commit doorbell, status/IRQ.
// Descriptors are pushed atomically into desc_fifo and handed to the tile controller.
module gemm_cmd_queue
    import gemm_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
    parameter int          DEPTH     = 4,
    parameter int          DIM_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              system_bus_en,
    input  logic              system_bus_rdwr,
    input  logic [31:0]       system_bus_addr,
    input  logic [31:0]       system_bus_wr_data,
    output logic [31:0]       system_bus_rd_data,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [31:0]       tile_A_addr,
    output logic [31:0]       tile_B_addr,
    output logic [31:0]       tile_C_addr,
    output logic [31:0]       tile_A_stride,
    output logic [31:0]       tile_B_stride,
    output logic [DIM_W-1:0]  msize,
    output logic [DIM_W-1:0]  ksize,
    output logic [DIM_W-1:0]  nsize,
    output logic              store,
    output logic              overwrite,
    input  logic              tile_done,
    output logic              irq
);

    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]       r_a_addr;
    logic [31:0]       r_b_addr;
    logic [31:0]       r_c_addr;
    logic [31:0]       r_a_stride;
    logic [31:0]       r_b_stride;
    logic              r_store;
    logic              r_overwrite;
    logic              r_irq_en;
    logic [DIM_W-1:0]  r_m;
    logic [DIM_W-1:0]  r_k;
    logic [DIM_W-1:0]  r_n;
    logic              r_overflow;
    logic              r_done_pend;
    logic [31:0]       r_done_cnt;

    logic [31:0]       w_off;
    logic              w_wr;
    logic              w_rd;
    logic              w_commit;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [CW-1:0]     w_count;
    logic [31:0]       w_status;
    gemm_desc_t        w_stage;
    gemm_desc_t        w_head;
    logic              w_unused_dim_hi;

    // Full-address match: an offset is only valid when the whole address matches.
    assign w_off    = system_bus_addr - BASE_ADDR;
    assign w_wr     = system_bus_en && system_bus_rdwr;
    assign w_rd     = system_bus_en && !system_bus_rdwr;
    assign w_commit = w_wr && (w_off == REG_COMMIT);
    assign w_pop    = desc_valid && desc_ready;

    assign w_stage = '{a_addr:    r_a_addr,
                       b_addr:    r_b_addr,
                       c_addr:    r_c_addr,
                       a_stride:  r_a_stride,
                       b_stride:  r_b_stride,
                       m:         DIM_MAX_W'(r_m),
                       k:         DIM_MAX_W'(r_k),
                       n:         DIM_MAX_W'(r_n),
                       store:     r_store,
                       overwrite: r_overwrite};

    desc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_commit),
        .pop   (w_pop),
        .din   (w_stage),
        .dout  (w_head),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    assign desc_valid      = !w_empty;
    assign tile_A_addr     = w_head.a_addr;
    assign tile_B_addr     = w_head.b_addr;
    assign tile_C_addr     = w_head.c_addr;
    assign tile_A_stride   = w_head.a_stride;
    assign tile_B_stride   = w_head.b_stride;
    assign msize           = w_head.m[DIM_W-1:0];
    assign ksize           = w_head.k[DIM_W-1:0];
    assign nsize           = w_head.n[DIM_W-1:0];
    assign store           = w_head.store;
    assign overwrite       = w_head.overwrite;
    assign w_unused_dim_hi = ^{w_head.m, w_head.k, w_head.n};
    assign irq             = r_irq_en && r_done_pend && w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_addr    <= '0;
            r_b_addr    <= '0;
            r_c_addr    <= '0;
            r_a_stride  <= '0;
            r_b_stride  <= '0;
            r_store     <= 1'b0;
            r_overwrite <= 1'b0;
            r_irq_en    <= 1'b0;
            r_m         <= '0;
            r_k         <= '0;
            r_n         <= '0;
        end else if (w_wr) begin
            case (w_off)
                REG_A_ADDR:   r_a_addr   <= system_bus_wr_data;
                REG_B_ADDR:   r_b_addr   <= system_bus_wr_data;
                REG_C_ADDR:   r_c_addr   <= system_bus_wr_data;
                REG_A_STRIDE: r_a_stride <= system_bus_wr_data;
                REG_B_STRIDE: r_b_stride <= system_bus_wr_data;
                REG_CTRL: begin
                    r_store     <= system_bus_wr_data[CTRL_STORE];
                    r_overwrite <= system_bus_wr_data[CTRL_OVERWRITE];
                    r_irq_en    <= system_bus_wr_data[CTRL_IRQ_EN];
                end
                REG_DIM: begin
                    r_m <= system_bus_wr_data[DIM_W-1:0];
                    r_k <= system_bus_wr_data[2*DIM_W-1:DIM_W];
                    r_n <= system_bus_wr_data[3*DIM_W-1:2*DIM_W];
                end
                default: ;
            endcase
        end
    end

    // Hardware set events take priority over software clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_done_pend <= 1'b0;
            r_done_cnt  <= '0;
        end else begin
            if (w_commit && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (w_wr && (w_off == REG_STATUS) && system_bus_wr_data[ST_OVERFLOW]) begin
                r_overflow <= 1'b0;
            end
            if (tile_done) begin
                r_done_pend <= 1'b1;
            end else if (w_wr && (w_off == REG_STATUS) && system_bus_wr_data[ST_DONE_PEND]) begin
                r_done_pend <= 1'b0;
            end
            if (w_wr && (w_off == REG_DONE_CNT)) begin
                r_done_cnt <= '0;
            end else if (tile_done) begin
                r_done_cnt <= r_done_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        w_status                      = '0;
        w_status[ST_EMPTY]            = w_empty;
        w_status[ST_FULL]             = w_full;
        w_status[ST_COUNT_LSB +: 8]   = 8'(w_count);
        w_status[ST_OVERFLOW]         = r_overflow;
        w_status[ST_DONE_PEND]        = r_done_pend;
    end

    always_comb begin
        system_bus_rd_data = '0;
        if (w_rd) begin
            case (w_off)
                REG_A_ADDR:   system_bus_rd_data = r_a_addr;
                REG_B_ADDR:   system_bus_rd_data = r_b_addr;
                REG_C_ADDR:   system_bus_rd_data = r_c_addr;
                REG_A_STRIDE: system_bus_rd_data = r_a_stride;
                REG_B_STRIDE: system_bus_rd_data = r_b_stride;
                REG_CTRL:     system_bus_rd_data = {29'b0, r_irq_en, r_overwrite, r_store};
                REG_DIM:      system_bus_rd_data = 32'({r_n, r_k, r_m});
                REG_STATUS:   system_bus_rd_data = w_status;
                REG_DONE_CNT: system_bus_rd_data = r_done_cnt;
                default:      system_bus_rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_cmd_queue.sv
// Bench for gemm_cmd_queue: directed register-map scenarios followed by random traffic,
// all checked every cycle against a queue-based model of the descriptor queue.
module tb_gemm_cmd_queue;

    localparam logic [31:0] BASE  = 32'h9000_0000;
    localparam int          DEPTH = 4;
    localparam int          DIM_W = 5;

    logic              clk;
    logic              rst;
    logic              en;
    logic              rdwr;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rd_data;
    logic              desc_valid;
    logic              desc_ready;
    logic [31:0]       t_a, t_b, t_c, t_as, t_bs;
    logic [DIM_W-1:0]  msize, ksize, nsize;
    logic              store, overwrite;
    logic              tile_done;
    logic              irq;

    gemm_cmd_queue #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .DIM_W     (DIM_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .system_bus_en      (en),
        .system_bus_rdwr    (rdwr),
        .system_bus_addr    (addr),
        .system_bus_wr_data (wdata),
        .system_bus_rd_data (rd_data),
        .desc_valid         (desc_valid),
        .desc_ready         (desc_ready),
        .tile_A_addr        (t_a),
        .tile_B_addr        (t_b),
        .tile_C_addr        (t_c),
        .tile_A_stride      (t_as),
        .tile_B_stride      (t_bs),
        .msize              (msize),
        .ksize              (ksize),
        .nsize              (nsize),
        .store              (store),
        .overwrite          (overwrite),
        .tile_done          (tile_done),
        .irq                (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b, c, as_, bs;
        logic [4:0]  m, k, n;
        logic        st, ow;
    } tdesc_t;

    tdesc_t      m_stage;
    tdesc_t      m_q[$];
    logic        m_irq_en;
    logic        m_ovf;
    logic        m_dp;
    logic [31:0] m_dcnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] last_rd;
    logic [31:0] last_ha;
    logic        last_valid;
    logic        last_irq;
    logic        last_store;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stage  = '{default: '0};
        m_q.delete();
        m_irq_en = 1'b0;
        m_ovf    = 1'b0;
        m_dp     = 1'b0;
        m_dcnt   = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        case (off)
            32'h00: return m_stage.a;
            32'h04: return m_stage.b;
            32'h08: return m_stage.c;
            32'h0C: return m_stage.as_;
            32'h10: return m_stage.bs;
            32'h14: return {29'b0, m_irq_en, m_stage.ow, m_stage.st};
            32'h18: return {17'b0, m_stage.n, m_stage.k, m_stage.m};
            32'h20: return {14'b0, m_dp, m_ovf, 8'(m_q.size()), 6'b0,
                            (m_q.size() == DEPTH), (m_q.size() == 0)};
            32'h24: return m_dcnt;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_update(input logic r, e, w, input logic [31:0] a, d,
                                input logic rdy, td);
        logic [31:0] off;
        logic        wr;
        if (r) begin
            model_reset();
            return;
        end
        off = a - BASE;
        wr  = e && w;
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (wr && off == 32'h1C) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_stage);
            else m_ovf = 1'b1;
        end
        if (wr && off == 32'h20) begin
            if (d[16]) m_ovf = 1'b0;
            if (d[17]) m_dp = 1'b0;
        end
        if (td) m_dp = 1'b1;
        if (wr && off == 32'h24) m_dcnt = '0;
        else if (td) m_dcnt = m_dcnt + 1;
        if (wr) begin
            case (off)
                32'h00: m_stage.a   = d;
                32'h04: m_stage.b   = d;
                32'h08: m_stage.c   = d;
                32'h0C: m_stage.as_ = d;
                32'h10: m_stage.bs  = d;
                32'h14: begin
                    m_stage.st = d[0];
                    m_stage.ow = d[1];
                    m_irq_en   = d[2];
                end
                32'h18: begin
                    m_stage.m = d[4:0];
                    m_stage.k = d[9:5];
                    m_stage.n = d[14:10];
                end
                default: ;
            endcase
        end
    endtask

    // One clock: drive on the falling edge, compare 1 ns later, advance the model at the rising edge.
    task automatic step(input logic r, e, w, input logic [31:0] a, d, input logic rdy, td);
        @(negedge clk);
        rst = r; en = e; rdwr = w; addr = a; wdata = d; desc_ready = rdy; tile_done = td;
        #1;
        check_val("rd_data", rd_data, (e && !w) ? model_read(a) : 32'h0);
        check_val("desc_valid", {31'b0, desc_valid}, {31'b0, (m_q.size() > 0)});
        check_val("irq", {31'b0, irq}, {31'b0, m_irq_en && m_dp && (m_q.size() == 0)});
        if (m_q.size() > 0) begin
            check_val("head_a", t_a, m_q[0].a);
            check_val("head_b", t_b, m_q[0].b);
            check_val("head_c", t_c, m_q[0].c);
            check_val("head_as", t_as, m_q[0].as_);
            check_val("head_bs", t_bs, m_q[0].bs);
            check_val("head_mkn", {17'b0, nsize, ksize, msize},
                      {17'b0, m_q[0].n, m_q[0].k, m_q[0].m});
            check_val("head_ctl", {30'b0, overwrite, store}, {30'b0, m_q[0].ow, m_q[0].st});
        end
        last_rd    = rd_data;
        last_ha    = t_a;
        last_valid = desc_valid;
        last_irq   = irq;
        last_store = store;
        @(posedge clk);
        model_update(r, e, w, a, d, rdy, td);
    endtask

    task automatic bus_wr(input logic [31:0] off, input logic [31:0] d,
                          input logic rdy = 1'b0, input logic td = 1'b0);
        step(1'b0, 1'b1, 1'b1, BASE + off, d, rdy, td);
    endtask

    task automatic bus_rd(input logic [31:0] off);
        step(1'b0, 1'b1, 1'b0, BASE + off, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rdy, input logic td);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rdy, td);
    endtask

    initial begin
        logic [31:0] ra, rd;
        int          sel;
        rst = 1'b1; en = 1'b0; rdwr = 1'b0; addr = '0; wdata = '0;
        desc_ready = 1'b0; tile_done = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state
        bus_rd(32'h20);
        check_val("rst_status", last_rd, 32'h0000_0001);
        check_val("rst_valid", {31'b0, last_valid}, 32'h0);
        check_val("rst_irq", {31'b0, last_irq}, 32'h0);
        check_val("rst_head_a", last_ha, 32'h0);
        bus_rd(32'h18);
        check_val("rst_dim", last_rd, 32'h0);

        // First descriptor
        bus_wr(32'h00, 32'h1000);
        bus_wr(32'h04, 32'h2000);
        bus_wr(32'h08, 32'h3000);
        bus_wr(32'h0C, 32'd64);
        bus_wr(32'h10, 32'd128);
        bus_wr(32'h14, 32'h1);
        bus_wr(32'h18, 32'h4104);
        bus_wr(32'h1C, 32'h0);
        bus_rd(32'h20);
        check_val("c1_valid", {31'b0, last_valid}, 32'h1);
        check_val("c1_a", last_ha, 32'h1000);
        check_val("c1_store", {31'b0, last_store}, 32'h1);
        check_val("c1_status", last_rd, 32'h0000_0100);
        bus_rd(32'h1C);
        check_val("commit_rd", last_rd, 32'h0);

        // Overflow on a fifth commit
        for (int i = 1; i <= 4; i++) begin
            bus_wr(32'h00, 32'h1000 + i * 32'h100);
            bus_wr(32'h1C, 32'h0);
        end
        bus_rd(32'h20);
        check_val("ovf_status", last_rd, 32'h0001_0402);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 1'b0);
            check_val("pop_order", last_ha, 32'h1000 + i * 32'h100);
        end
        bus_wr(32'h20, 32'h0001_0000);
        bus_rd(32'h20);
        check_val("ovf_clear", last_rd, 32'h0000_0001);

        // Commit while full and popping
        for (int i = 0; i < 4; i++) begin
            bus_wr(32'h00, 32'h5000 + i);
            bus_wr(32'h1C, 32'h0);
        end
        bus_wr(32'h00, 32'h6000);
        bus_wr(32'h1C, 32'h0, 1'b1);
        bus_rd(32'h20);
        check_val("full_pop_status", last_rd, 32'h0000_0402);
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
        check_val("full_pop_last", last_ha, 32'h6000);

        // Drain interrupt and done counter
        bus_wr(32'h14, 32'h4);
        bus_wr(32'h1C, 32'h0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b1);
        bus_rd(32'h20);
        check_val("irq_set", {31'b0, last_irq}, 32'h1);
        check_val("dp_status", last_rd, 32'h0002_0001);
        bus_wr(32'h20, 32'h0002_0000);
        bus_rd(32'h24);
        check_val("irq_clr", {31'b0, last_irq}, 32'h0);
        check_val("dcnt_one", last_rd, 32'h1);
        bus_wr(32'h24, 32'h0);
        bus_rd(32'h24);
        check_val("dcnt_clr", last_rd, 32'h0);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        bus_wr(32'h24, 32'h0, 1'b0, 1'b1);
        bus_rd(32'h24);
        check_val("dcnt_clr_wins", last_rd, 32'h0);

        // Reset with entries queued
        for (int i = 0; i < 3; i++) bus_wr(32'h1C, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus_rd(32'h20);
        check_val("mid_rst_status", last_rd, 32'h0000_0001);
        check_val("mid_rst_valid", {31'b0, last_valid}, 32'h0);
        bus_rd(32'h00);
        check_val("mid_rst_stage", last_rd, 32'h0);

        // Random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sel = $urandom_range(0, 15);
            if (sel < 4) ra = BASE + 32'h1C;
            else if (sel < 13) ra = BASE + 32'($urandom_range(0, 9)) * 4;
            else if (sel == 13) ra = BASE + 32'h28;
            else if (sel == 14) ra = BASE + 32'h02;
            else ra = 32'h1000_001C;
            rd = $urandom();
            if ($urandom_range(0, 3) == 0) rd[16] = 1'b0;
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1, ra, rd,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gemm_cmd_queue.md
# gemm_cmd_queue

Memory-mapped GEMM command queue between the system bus and the GEMM tile controller. Software writes descriptor fields into staging registers, then writes a commit doorbell that pushes the whole descriptor atomically into a DEPTH-entry FIFO. The controller consumes descriptors with a valid/ready handshake. Status, occupancy, sticky overflow, completion count and a drain interrupt are software-visible.

## Interface
- BASE_ADDR, 32'h9000_0000, byte address of register 0x00
- DEPTH, 4, descriptor FIFO entries; power of two, 2..128
- DIM_W, 5, width of each of m/k/n tile sizes
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- system_bus_en  in  1  bus access this cycle
- system_bus_rdwr  in  1  1 = write, 0 = read
- system_bus_addr  in  32  byte address
- system_bus_wr_data  in  32  write data
- system_bus_rd_data  out  32  read data, combinational
- desc_valid  out  1  FIFO head holds a descriptor
- desc_ready  in  1  controller accepts the head this cycle
- tile_A_addr, tile_B_addr, tile_C_addr, tile_A_stride, tile_B_stride  out  32 each  head descriptor fields
- msize, ksize, nsize  out  DIM_W each  head tile dimensions
- store, overwrite  out  1 each  head control bits
- tile_done  in  1  one-cycle pulse per completed tile
- irq  out  1  level interrupt

## Operation
- Register map (offset from BASE_ADDR):
  - 0x00 A addr, 0x04 B addr, 0x08 C addr, 0x0C A stride, 0x10 B stride: staging, R/W.
  - 0x14 control, R/W: [0] store, [1] overwrite, [2] irq_en. irq_en is not queued.
  - 0x18 dimension, R/W: m = [DIM_W-1:0], k = [2*DIM_W-1:DIM_W], n = [3*DIM_W-1:2*DIM_W]. Unused bits read 0.
  - 0x1C commit, W: any write pushes the staged descriptor. Reads return 0.
  - 0x20 status, R: [0] empty, [1] full, [15:8] count, [16] overflow, [17] done_pending. Writing 1 to bit 16 or 17 clears that flag; other bits are ignored.
  - 0x24 done_count, R: 32-bit count of tile_done pulses, wraps at 2^32. Any write clears it to 0.
- Decode is an exact full-address match. Unmapped writes are ignored.
- Reads: rd_data = addressed value when en && !rdwr. rd_data = 0 otherwise, and 0 for unmapped addresses.
- Staging registers keep their values after a commit, so software rewrites only the fields that change.
- Commit behaviour:
  - Not full: push.
  - Full and desc_ready && desc_valid in the same cycle: push and pop both occur; count is unchanged.
  - Full otherwise: descriptor dropped, overflow set.
- Pop occurs when desc_valid && desc_ready. desc_ready while empty has no effect.
- done_pending is set by tile_done. A same-cycle tile_done wins over a software clear.
- irq = irq_en && done_pending && empty.
- Reset clears all staging registers, FIFO storage, pointers, count, flags and done_count. After reset every output is 0 except status reads (empty = 1).

## Timing
- Staging or commit write at edge N: the new value is readable in cycle N+1. A committed descriptor appears on the head outputs with desc_valid = 1 in cycle N+1 (first-word fall-through, 1-cycle latency).
- Head outputs are stable while desc_valid && !desc_ready. The next entry appears the cycle after a pop.
- Count/full/empty update at the edge of push or pop. A simultaneous push and pop on a non-empty FIFO leaves count unchanged.
- A commit onto an empty FIFO with desc_ready high: no bypass; desc_valid rises the next cycle.
- A tile_done on the same edge as a done_count clear: the clear wins and the result is 0.
- irq is combinational from registered state and has no extra latency.
- Reset mid-operation discards all queued descriptors within one cycle.

## Structure
- Package gemm_cfg_pkg holds:
  - the gemm_desc_t packed struct (five 32-bit addresses/strides, m/k/n, store, overwrite);
  - register offset localparams REG_A_ADDR through REG_DONE_CNT;
  - status bit-index constants.
- Sub-module desc_fifo: generic synchronous FIFO of gemm_desc_t.
  - Parameter DEPTH.
  - Ports push, pop, din, dout, count, empty, full.
  - Registered pointers; count is $clog2(DEPTH+1) bits.
- The top level contains only the decode, staging registers, flags, counter and irq logic.

## Test plan
- Reset, then read 0x20 → 0x0000_0001; desc_valid = 0; irq = 0. Read 0x18 → 0.
- Stage A = 0x1000, B = 0x2000, C = 0x3000, strides 64/128, control = 0x1, dimension = m4/k8/n16 (0x4104). Commit with desc_ready = 0 → next cycle desc_valid = 1, fields match, store = 1, count = 1.
- DEPTH = 4: five commits with desc_ready = 0 → status = 0x0001_0402 (overflow, count 4, full). Pop all → the first four descriptors come out in order. Write 0x1_0000 to 0x20 → overflow clears.
- Full FIFO, commit in the same cycle as a pop → count stays 4, no overflow, the new descriptor is last out.
- control = 0x4, one descriptor popped, tile_done pulse → irq = 1 the next cycle. Write 0x2_0000 to 0x20 → irq = 0. done_count reads 1, then write → 0.
- Assert rst with 3 entries queued → next cycle count = 0, desc_valid = 0, staging reads 0.
